// File: rtl/ddr2_bringup_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the DDR2 bring-up sequencer.
package ddr2_bringup_pkg;

  localparam int DEF_RST_HOLD_CYC  = 25;
  localparam int DEF_RDY_TIMEOUT   = 4096;
  localparam int DEF_PHY_RST_DELAY = 16;
  localparam int DEF_MAX_RETRY     = 3;

  typedef enum logic [2:0] {
    WAIT_CLK,
    HOLD_RST,
    WAIT_RDY,
    PHY_RST,
    DONE,
    FAIL
  } state_e;

  // A limit of 1 would give a zero-width counter, so keep at least one bit.
  function automatic int cntWidth(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/ddr2_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk200 domain; clears to 0 on reset.
module ddr2_sync2 (
  input  logic clk200,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ddr2_bringup_seq.sv
// DDR2 clocking bring-up: waits for DCM lock, pulses IDELAYCTRL reset, waits for RDY, then releases the PHY.
// Optional retry-on-timeout behaviour is enabled by defining DDR2_BRINGUP_RETRY_EN.
module ddr2_bringup_seq
  import ddr2_bringup_pkg::*;
#(
  parameter int RST_HOLD_CYC  = DEF_RST_HOLD_CYC,
  parameter int RDY_TIMEOUT   = DEF_RDY_TIMEOUT,
  parameter int PHY_RST_DELAY = DEF_PHY_RST_DELAY,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk200,
  input  logic       rst,
  input  logic       clk200_ready,
  input  logic       idelay_ctrl_rdy,
  output logic       rst200,
  output logic       phy_rst,
  output logic       init_done,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int HOLD_W = cntWidth(RST_HOLD_CYC);
  localparam int TMO_W  = cntWidth(RDY_TIMEOUT);
  localparam int PHY_W  = cntWidth(PHY_RST_DELAY);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RDY_TIMEOUT - 1);
  localparam logic [PHY_W-1:0]  PHY_LAST  = PHY_W'(PHY_RST_DELAY - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

  logic              w_lockSync;
  logic              w_rdySync;
  state_e            w_nextState;
  logic              w_retryInc;

  state_e            r_state;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [TMO_W-1:0]  r_tmoCnt;
  logic [PHY_W-1:0]  r_phyCnt;
  logic              r_rst200;
  logic              r_phyRst;
  logic              r_initDone;
  logic              r_fail;
  logic [1:0]        r_retryCnt;

  ddr2_sync2 u_lockSync (
    .clk200  (clk200),
    .rst     (rst),
    .i_async (clk200_ready),
    .o_sync  (w_lockSync)
  );

  ddr2_sync2 u_rdySync (
    .clk200  (clk200),
    .rst     (rst),
    .i_async (idelay_ctrl_rdy),
    .o_sync  (w_rdySync)
  );

  // Losing lock outranks every other event; only FAIL ignores it.
  always_comb begin
    w_nextState = r_state;
    w_retryInc  = 1'b0;
    if (r_state != FAIL && !w_lockSync) begin
      w_nextState = WAIT_CLK;
    end else begin
      case (r_state)
        WAIT_CLK: w_nextState = HOLD_RST;
        HOLD_RST: begin
          if (r_holdCnt == HOLD_LAST) w_nextState = WAIT_RDY;
        end
        WAIT_RDY: begin
          if (w_rdySync) begin
            w_nextState = PHY_RST;
          end else if (r_tmoCnt == TMO_LAST) begin
`ifdef DDR2_BRINGUP_RETRY_EN
            if (r_retryCnt < RETRY_MAX) begin
              w_nextState = HOLD_RST;
              w_retryInc  = 1'b1;
            end else begin
              w_nextState = FAIL;
            end
`else
            w_nextState = FAIL;
`endif
          end
        end
        PHY_RST: begin
          if (r_phyCnt == PHY_LAST) w_nextState = DONE;
        end
        DONE: begin
          if (!w_rdySync) begin
`ifdef DDR2_BRINGUP_RETRY_EN
            w_nextState = HOLD_RST;
            w_retryInc  = 1'b1;
`else
            w_nextState = FAIL;
`endif
          end
        end
        FAIL:    w_nextState = FAIL;
        default: w_nextState = WAIT_CLK;
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state register.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_state    <= WAIT_CLK;
      r_holdCnt  <= '0;
      r_tmoCnt   <= '0;
      r_phyCnt   <= '0;
      r_rst200   <= 1'b1;
      r_phyRst   <= 1'b1;
      r_initDone <= 1'b0;
      r_fail     <= 1'b0;
      r_retryCnt <= 2'd0;
    end else begin
      r_state   <= w_nextState;
      r_holdCnt <= '0;
      r_tmoCnt  <= '0;
      r_phyCnt  <= '0;
      if (w_nextState == r_state) begin
        case (r_state)
          HOLD_RST: r_holdCnt <= r_holdCnt + 1'b1;
          WAIT_RDY: r_tmoCnt  <= r_tmoCnt + 1'b1;
          PHY_RST:  r_phyCnt  <= r_phyCnt + 1'b1;
          default:  ;
        endcase
      end
      r_rst200   <= (w_nextState == WAIT_CLK) || (w_nextState == HOLD_RST) || (w_nextState == FAIL);
      r_phyRst   <= (w_nextState != DONE);
      r_initDone <= (w_nextState == DONE);
      r_fail     <= (w_nextState == FAIL);
      if (w_retryInc && r_retryCnt != RETRY_MAX) r_retryCnt <= r_retryCnt + 2'd1;
    end
  end

  assign rst200    = r_rst200;
  assign phy_rst   = r_phyRst;
  assign init_done = r_initDone;
  assign fail      = r_fail;
  assign retry_cnt = r_retryCnt;

endmodule

// File: tb/tb_ddr2_bringup_seq.sv
// Bench for ddr2_bringup_seq: a vector table for the nominal bring-up plus hand sequences for lock loss,
// timeouts and asynchronous reset; expectations follow whether DDR2_BRINGUP_RETRY_EN is defined.
`timescale 1ns/1ps
module tb_ddr2_bringup_seq;

  logic       clk200 = 1'b0;
  logic       rst;
  logic       clk200_ready;
  logic       idelay_ctrl_rdy;
  logic       rst200;
  logic       phy_rst;
  logic       init_done;
  logic       fail;
  logic [1:0] retry_cnt;

  // Expected outputs packed as {rst200, phy_rst, init_done, fail, retry_cnt[1:0]}.
  typedef struct {
    logic       lock;
    logic       rdy;
    int         cycles;
    logic [5:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  ddr2_bringup_seq dut (
    .clk200          (clk200),
    .rst             (rst),
    .clk200_ready    (clk200_ready),
    .idelay_ctrl_rdy (idelay_ctrl_rdy),
    .rst200          (rst200),
    .phy_rst         (phy_rst),
    .init_done       (init_done),
    .fail            (fail),
    .retry_cnt       (retry_cnt)
  );

  always #2.5 clk200 = ~clk200;

  function automatic logic [5:0] outs(input logic r, input logic p, input logic d, input logic f,
                                      input logic [1:0] rc);
    return {r, p, d, f, rc};
  endfunction

  function automatic vec_t mkVec(input logic lock, input logic rdy, input int cycles,
                                 input logic [5:0] exp, input string name);
    vec_t v;
    v.lock   = lock;
    v.rdy    = rdy;
    v.cycles = cycles;
    v.exp    = exp;
    v.name   = name;
    return v;
  endfunction

  task automatic pushExp(input logic [5:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] act;
    e   = expQ.pop_front();
    act = {rst200, phy_rst, init_done, fail, retry_cnt};
    vecCount++;
    if (act !== e.exp) begin
      missCount++;
      $display("[TB] FAIL %s: got rst200/phy_rst/init_done/fail/retry=%b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
               e.name, act[5], act[4], act[3], act[2], act[1:0],
               e.exp[5], e.exp[4], e.exp[3], e.exp[2], e.exp[1:0]);
    end
  endtask

  // Called on a falling edge: drive, advance the given number of rising edges, compare on a falling edge.
  task automatic applyStimulus(input logic lock, input logic rdy, input int cycles,
                               input logic [5:0] exp, input string name);
    clk200_ready    = lock;
    idelay_ctrl_rdy = rdy;
    pushExp(exp, name);
    repeat (cycles) @(negedge clk200);
    checkOutput();
  endtask

  task automatic doReset();
    rst             = 1'b1;
    clk200_ready    = 1'b0;
    idelay_ctrl_rdy = 1'b0;
    repeat (2) @(negedge clk200);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    clk200_ready    = 1'b0;
    idelay_ctrl_rdy = 1'b0;
    pushExp(outs(1, 1, 0, 0, 2'd0), "reset_state");
    #1;
    checkOutput();
    repeat (2) @(negedge clk200);
    rst = 1'b0;

    // Nominal bring-up, then RDY loss while DONE.
    vecs.push_back(mkVec(1, 0, 27, outs(1, 1, 0, 0, 2'd0), "hold_last_cycle"));
    vecs.push_back(mkVec(1, 0, 1,  outs(0, 1, 0, 0, 2'd0), "rst200_fall"));
    vecs.push_back(mkVec(1, 0, 10, outs(0, 1, 0, 0, 2'd0), "wait_rdy"));
    vecs.push_back(mkVec(1, 1, 18, outs(0, 1, 0, 0, 2'd0), "phy_rst_last"));
    vecs.push_back(mkVec(1, 1, 1,  outs(0, 0, 1, 0, 2'd0), "done"));
    vecs.push_back(mkVec(1, 1, 20, outs(0, 0, 1, 0, 2'd0), "done_stable"));
    vecs.push_back(mkVec(1, 0, 2,  outs(0, 0, 1, 0, 2'd0), "done_before_loss"));
`ifdef DDR2_BRINGUP_RETRY_EN
    vecs.push_back(mkVec(1, 0, 1,  outs(1, 1, 0, 0, 2'd1), "rdy_loss_rehold"));
    vecs.push_back(mkVec(1, 1, 24, outs(1, 1, 0, 0, 2'd1), "rehold_last"));
    vecs.push_back(mkVec(1, 1, 1,  outs(0, 1, 0, 0, 2'd1), "rewait_rdy"));
    vecs.push_back(mkVec(1, 1, 1,  outs(0, 1, 0, 0, 2'd1), "rephy_first"));
    vecs.push_back(mkVec(1, 1, 15, outs(0, 1, 0, 0, 2'd1), "rephy_last"));
    vecs.push_back(mkVec(1, 1, 1,  outs(0, 0, 1, 0, 2'd1), "redone"));
`else
    vecs.push_back(mkVec(1, 0, 1,  outs(1, 1, 0, 1, 2'd0), "rdy_loss_fail"));
    vecs.push_back(mkVec(1, 1, 50, outs(1, 1, 0, 1, 2'd0), "fail_sticky"));
    vecs.push_back(mkVec(0, 1, 10, outs(1, 1, 0, 1, 2'd0), "fail_ignores_lock"));
`endif
    foreach (vecs[i]) applyStimulus(vecs[i].lock, vecs[i].rdy, vecs[i].cycles, vecs[i].exp, vecs[i].name);

    // Lock lost during PHY_RST, then relock and a full repeat.
    doReset();
    applyStimulus(1, 1, 33, outs(0, 1, 0, 0, 2'd0), "b_phy_rst");
    applyStimulus(0, 1, 2,  outs(0, 1, 0, 0, 2'd0), "b_lock_drop_sync");
    applyStimulus(0, 1, 1,  outs(1, 1, 0, 0, 2'd0), "b_wait_clk");
    applyStimulus(0, 1, 20, outs(1, 1, 0, 0, 2'd0), "b_stay_wait_clk");
    applyStimulus(1, 1, 27, outs(1, 1, 0, 0, 2'd0), "b_rehold_last");
    applyStimulus(1, 1, 1,  outs(0, 1, 0, 0, 2'd0), "b_rst200_fall");
    applyStimulus(1, 1, 16, outs(0, 1, 0, 0, 2'd0), "b_phy_rst_last");
    applyStimulus(1, 1, 1,  outs(0, 0, 1, 0, 2'd0), "b_done");

    // RDY never arrives: timeout handling.
    doReset();
    applyStimulus(1, 0, 4123, outs(0, 1, 0, 0, 2'd0), "c_timeout_edge");
`ifdef DDR2_BRINGUP_RETRY_EN
    applyStimulus(1, 0, 1, outs(1, 1, 0, 0, 2'd1), "c_retry_1");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 0, 4120, outs(0, 1, 0, 0, 2'(k)), "c_retry_wait");
      if (k < 3) applyStimulus(1, 0, 1, outs(1, 1, 0, 0, 2'(k + 1)), "c_retry_next");
      else       applyStimulus(1, 0, 1, outs(1, 1, 0, 1, 2'd3), "c_retry_exhausted");
    end
    applyStimulus(1, 1, 100, outs(1, 1, 0, 1, 2'd3), "c_fail_sticky");
`else
    applyStimulus(1, 0, 1,   outs(1, 1, 0, 1, 2'd0), "c_timeout_fail");
    applyStimulus(1, 1, 100, outs(1, 1, 0, 1, 2'd0), "c_fail_sticky");
`endif

    // Asynchronous reset in WAIT_RDY must act before the next rising edge.
    doReset();
    applyStimulus(1, 0, 40, outs(0, 1, 0, 0, 2'd0), "d_wait_rdy");
    rst = 1'b1;
    pushExp(outs(1, 1, 0, 0, 2'd0), "d_async_reset");
    #1;
    checkOutput();
    @(negedge clk200);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
